// File: rtl/nx_link_fifo_if.sv
// Valid/ready message stream between a link FIFO and a node port.
// The producer drives data/valid, the consumer drives ready.
interface nx_link_fifo_if #(
  parameter int unsigned STREAM_WIDTH = 32
);
  logic [STREAM_WIDTH-1:0] data;
  logic                    valid;
  logic                    ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/nx_link_fifo.sv
// Elastic buffer on an inter-node message link. Every output is taken from registered
// state, which breaks the combinational ready path between tiles.
module nx_link_fifo #(
  parameter int unsigned STREAM_WIDTH = 32,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  nx_link_fifo_if.slave            wr_if,
  nx_link_fifo_if.master           rd_if,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [STREAM_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  logic [AW:0]             w_wr_ptr_nxt;
  logic [AW:0]             w_rd_ptr_nxt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;

  // The extra pointer bit tells full from empty when the low bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push = wr_if.valid && !w_full;
  assign w_pop  = !w_empty && rd_if.ready;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PtrOne;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_if.data;
    end
  end

  assign wr_if.ready = !w_full;
  assign rd_if.valid = !w_empty;
  assign rd_if.data  = r_mem[r_rd_ptr[AW-1:0]];
  assign level_o     = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_nx_link_fifo.sv
// Self-checking bench for nx_link_fifo: directed scenarios plus a randomized stall run,
// all compared against a queue model of an ideal FIFO.
module tb_nx_link_fifo;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] level;

  nx_link_fifo_if #(.STREAM_WIDTH(W)) wr_bus ();
  nx_link_fifo_if #(.STREAM_WIDTH(W)) rd_bus ();

  nx_link_fifo #(
    .STREAM_WIDTH(W),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .wr_if  (wr_bus),
    .rd_if  (rd_bus),
    .level_o(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  logic [4:0]   exp_st;
  logic [4:0]   got_st;

  task automatic drive(input logic wv, input logic [W-1:0] wd, input logic rr);
    wr_bus.valid = wv;
    wr_bus.data  = wd;
    rd_bus.ready = rr;
  endtask

  // Advance one clock; the model applies whatever an ideal FIFO would transfer.
  task automatic tick();
    logic         push;
    logic         pop;
    logic [W-1:0] d;
    push = wr_bus.valid && (q.size() < DEPTH);
    pop  = rd_bus.ready && (q.size() != 0);
    d    = wr_bus.data;
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic model_status();
    exp_st = {(q.size() != 0), (q.size() < DEPTH), 3'(q.size())};
    got_st = {rd_bus.valid, wr_bus.ready, level};
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    total++;
    if ({rd_bus.valid, wr_bus.ready, level} !== 5'b0_1_000) begin
      bad++;
      $display("FAIL reset_status got=%b exp=%b", {rd_bus.valid, wr_bus.ready, level}, 5'b01000);
    end
    total++;
    if (rd_bus.data !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=%h", rd_bus.data, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    drive(1'b1, 32'hA5A5_0001, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    total++;
    if ({rd_bus.valid, wr_bus.ready, level} !== 5'b1_1_001) begin
      bad++;
      $display("FAIL single_status got=%b exp=%b", {rd_bus.valid, wr_bus.ready, level}, 5'b11001);
    end
    total++;
    if (rd_bus.data !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL single_data got=%h exp=%h", rd_bus.data, 32'hA5A5_0001);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    total++;
    if ({rd_bus.valid, wr_bus.ready, level} !== 5'b0_1_000) begin
      bad++;
      $display("FAIL single_drain got=%b exp=%b", {rd_bus.valid, wr_bus.ready, level}, 5'b01000);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b0);
      tick();
    end
    total++;
    if ({rd_bus.valid, wr_bus.ready, level} !== 5'b1_0_100) begin
      bad++;
      $display("FAIL fill_full got=%b exp=%b", {rd_bus.valid, wr_bus.ready, level}, 5'b10100);
    end
    drive(1'b1, 32'h5, 1'b0);
    tick();
    total++;
    if ({rd_bus.valid, wr_bus.ready, level, rd_bus.data} !== {5'b1_0_100, 32'h1}) begin
      bad++;
      $display("FAIL fill_holdoff got=%b/%h exp=%b/%h", {rd_bus.valid, wr_bus.ready, level},
               rd_bus.data, 5'b10100, 32'h1);
    end
  endtask

  task automatic test_full_pop();
    logic [W-1:0] exp_seq [4];
    exp_seq = '{32'h2, 32'h3, 32'h4, 32'h5};
    drive(1'b1, 32'h5, 1'b1);
    total++;
    if (wr_bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL fullpop_refuse got=%b exp=%b", wr_bus.ready, 1'b0);
    end
    tick();
    total++;
    if ({rd_bus.valid, wr_bus.ready, level, rd_bus.data} !== {5'b1_1_011, 32'h2}) begin
      bad++;
      $display("FAIL fullpop_after got=%b/%h exp=%b/%h", {rd_bus.valid, wr_bus.ready, level},
               rd_bus.data, 5'b11011, 32'h2);
    end
    drive(1'b1, 32'h5, 1'b0);
    tick();
    total++;
    if ({rd_bus.valid, wr_bus.ready, level} !== 5'b1_0_100) begin
      bad++;
      $display("FAIL fullpop_accept got=%b exp=%b", {rd_bus.valid, wr_bus.ready, level}, 5'b10100);
    end
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_bus.data !== exp_seq[k] || rd_bus.valid !== 1'b1) begin
        bad++;
        $display("FAIL fullpop_order[%0d] got=%h/%b exp=%h/1", k, rd_bus.data, rd_bus.valid,
                 exp_seq[k]);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    total++;
    if ({rd_bus.valid, wr_bus.ready, level} !== 5'b0_1_000) begin
      bad++;
      $display("FAIL fullpop_empty got=%b exp=%b", {rd_bus.valid, wr_bus.ready, level}, 5'b01000);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0, 1'b1);
    tick();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, W'(i), 1'b1);
      total++;
      if ({rd_bus.valid, wr_bus.ready, level, rd_bus.data} !== {5'b1_1_001, W'(i - 1)}) begin
        bad++;
        $display("FAIL b2b[%0d] got=%b/%h exp=%b/%h", i, {rd_bus.valid, wr_bus.ready, level},
                 rd_bus.data, 5'b11001, W'(i - 1));
      end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    total++;
    if (rd_bus.data !== 32'd20) begin
      bad++;
      $display("FAIL b2b_last got=%h exp=%h", rd_bus.data, 32'd20);
    end
    tick();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_random();
    int           sent = 0;
    int           got  = 0;
    int           errs = 0;
    logic         wv   = 1'b0;
    logic         hold = 1'b0;
    logic         rr;
    logic [W-1:0] wd   = '0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      if (!hold) begin
        wv = (sent < 1000) && ($urandom_range(3) != 0);
        wd = $urandom;
      end
      rr = ($urandom_range(2) != 0);
      drive(wv, wd, rr);
      model_status();
      total++;
      if (got_st !== exp_st) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL rand_status cyc=%0d got=%b exp=%b", cyc, got_st, exp_st);
      end
      if (q.size() != 0) begin
        total++;
        if (rd_bus.data !== q[0]) begin
          bad++;
          errs++;
          if (errs < 10) $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, rd_bus.data, q[0]);
        end
      end
      if (wv && q.size() < DEPTH) sent++;
      if (rr && q.size() != 0) got++;
      hold = wv && (q.size() >= DEPTH);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    total++;
    if (got != 1000) begin
      bad++;
      $display("FAIL rand_count got=%0d exp=%0d", got, 1000);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hD000_0000 + W'(i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    total++;
    if ({rd_bus.valid, wr_bus.ready, level, rd_bus.data} !== {5'b0_1_000, 32'h0}) begin
      bad++;
      $display("FAIL midreset got=%b/%h exp=%b/%h", {rd_bus.valid, wr_bus.ready, level},
               rd_bus.data, 5'b01000, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h0000_BEEF, 1'b0);
    tick();
    drive(1'b1, 32'h0000_CAFE, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    total++;
    if ({rd_bus.valid, wr_bus.ready, level, rd_bus.data} !== {5'b1_1_010, 32'h0000_BEEF}) begin
      bad++;
      $display("FAIL midreset_after got=%b/%h exp=%b/%h", {rd_bus.valid, wr_bus.ready, level},
               rd_bus.data, 5'b11010, 32'h0000_BEEF);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
